// File: rtl/slant_link_pkg.sv
// Shared definitions for the 4-lane, 6-bit slant link (transmit and receive sides).
package slant_link_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 6;
  localparam int unsigned PAY_W  = 5;
  localparam int unsigned MARK_W = 24;
  localparam int unsigned HS_W   = 8;

  localparam logic [MARK_W-1:0] FRAME1_MARK = 24'haab155;
  localparam logic [MARK_W-1:0] FRAME0_MARK = 24'haa8d55;
  localparam logic [HS_W-1:0]   HSYNC_MARK  = 8'h55;

  typedef enum logic [1:0] {
    SYM_DATA = 2'd0,
    SYM_ONE  = 2'd1,
    SYM_BAD  = 2'd2
  } sym_class_t;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_HSYNC = 2'd2
  } rx_state_t;

  // One symbol across all lanes, lane3 in the MSBs.
  typedef struct packed {
    logic [LANE_W-1:0] l3;
    logic [LANE_W-1:0] l2;
    logic [LANE_W-1:0] l1;
    logic [LANE_W-1:0] l0;
  } lane_sym_t;

  // All-ones is a marker 1; any lane with bit5 set otherwise is illegal.
  function automatic sym_class_t classify(input lane_sym_t s);
    sym_class_t c;
    c = SYM_BAD;
    if (s == '1) begin
      c = SYM_ONE;
    end else if (!s.l3[LANE_W-1] && !s.l2[LANE_W-1] &&
                 !s.l1[LANE_W-1] && !s.l0[LANE_W-1]) begin
      c = SYM_DATA;
    end
    return c;
  endfunction

  // All-zeros doubles as a marker 0 and a legal data symbol.
  function automatic logic is_zero_sym(input lane_sym_t s);
    return (s == '0);
  endfunction

endpackage

// File: rtl/slant_marker_detect.sv
// Symbol classifier plus the 24-symbol frame-marker shifter and compare.
module slant_marker_detect
  import slant_link_pkg::*;
#(
  parameter logic [MARK_W-1:0] FRAME1 = FRAME1_MARK,
  parameter logic [MARK_W-1:0] FRAME0 = FRAME0_MARK
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_valid,
  input  lane_sym_t i_sym,
  output logic      o_is_one_c,
  output logic      o_is_zero_c,
  output logic      o_is_bad_c,
  output logic      o_match1_c,
  output logic      o_match0_c
);

  sym_class_t        w_class;
  logic [MARK_W-1:0] w_shift_in;
  logic [MARK_W-1:0] r_shift;

  assign w_class     = classify(i_sym);
  assign o_is_one_c  = (w_class == SYM_ONE);
  assign o_is_bad_c  = (w_class == SYM_BAD);
  assign o_is_zero_c = is_zero_sym(i_sym);

  // Compare against the value including the current symbol so it can win priority.
  assign w_shift_in = {r_shift[MARK_W-2:0], o_is_one_c};
  assign o_match1_c = i_valid && (w_shift_in == FRAME1);
  assign o_match0_c = i_valid && (w_shift_in == FRAME0);

  // Marker history; cleared on a match so overlapping markers cannot retrigger.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
    end else if (i_valid) begin
      if (o_match1_c || o_match0_c) begin
        r_shift <= '0;
      end else begin
        r_shift <= w_shift_in;
      end
    end
  end

endmodule

// File: rtl/slant_rx_deframer.sv
// Receive deframer: frame lock, line-marker check and per-lane {Y,C} pair reassembly.
module slant_rx_deframer
  import slant_link_pkg::*;
#(
  parameter int unsigned       LINE_SYMS = 160,
  parameter int unsigned       LINES     = 480,
  parameter logic [MARK_W-1:0] FRAME1    = FRAME1_MARK,
  parameter logic [MARK_W-1:0] FRAME0    = FRAME0_MARK,
  parameter logic [HS_W-1:0]   HSYNC     = HSYNC_MARK
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        RxValid,
  input  logic [5:0]  Rx0Data,
  input  logic [5:0]  Rx1Data,
  input  logic [5:0]  Rx2Data,
  input  logic [5:0]  Rx3Data,
  output logic        PixValid,
  output logic [19:0] PixY,
  output logic [19:0] PixC,
  output logic [8:0]  PixLine,
  output logic [7:0]  PixCol,
  output logic        FrameStart,
  output logic        FrameOdd,
  output logic        FrameDone,
  output logic        SyncErr,
  output logic [15:0] ErrCount,
  output logic        Locked
);

  localparam int unsigned SYM_W  = 8;
  localparam int unsigned LINE_W = 9;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned PIX_W  = LANES * PAY_W;
  localparam int unsigned ERR_W  = 16;

  localparam logic [SYM_W-1:0]  LAST_SYM  = SYM_W'(LINE_SYMS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(HS_W - 1);

  lane_sym_t          w_sym;
  logic [PIX_W-1:0]   w_payload;
  logic               w_is_one;
  logic               w_is_zero;
  logic               w_is_bad;
  logic               w_match1;
  logic               w_match0;
  logic               w_match;
  logic               w_hs_exp;

  rx_state_t          r_state;
  rx_state_t          w_state_nxt;
  logic [SYM_W-1:0]   r_sym;
  logic [SYM_W-1:0]   w_sym_nxt;
  logic [LINE_W-1:0]  r_line;
  logic [LINE_W-1:0]  w_line_nxt;
  logic [BIT_W-1:0]   r_bit;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [PIX_W-1:0]   r_y;
  logic [PIX_W-1:0]   w_y_nxt;
  logic               w_pix_valid;
  logic               w_fstart;
  logic               w_fdone;
  logic               w_err;

  assign w_sym     = {Rx3Data, Rx2Data, Rx1Data, Rx0Data};
  assign w_payload = {Rx3Data[PAY_W-1:0], Rx2Data[PAY_W-1:0],
                      Rx1Data[PAY_W-1:0], Rx0Data[PAY_W-1:0]};
  assign w_match   = w_match1 | w_match0;
  assign w_hs_exp  = HSYNC[LAST_BIT - r_bit];

  slant_marker_detect #(
    .FRAME1 (FRAME1),
    .FRAME0 (FRAME0)
  ) u_marker (
    .i_clk       (Cclk),
    .i_rst_n     (rstn),
    .i_valid     (RxValid),
    .i_sym       (w_sym),
    .o_is_one_c  (w_is_one),
    .o_is_zero_c (w_is_zero),
    .o_is_bad_c  (w_is_bad),
    .o_match1_c  (w_match1),
    .o_match0_c  (w_match0)
  );

  // State register.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, counters and event strobes; a frame match overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_sym_nxt   = r_sym;
    w_line_nxt  = r_line;
    w_bit_nxt   = r_bit;
    w_y_nxt     = r_y;
    w_pix_valid = 1'b0;
    w_fstart    = 1'b0;
    w_fdone     = 1'b0;
    w_err       = 1'b0;
    if (RxValid) begin
      if (w_match) begin
        w_state_nxt = ST_DATA;
        w_sym_nxt   = '0;
        w_line_nxt  = '0;
        w_bit_nxt   = '0;
        w_fstart    = 1'b1;
        w_err       = (r_state != ST_HUNT);
      end else begin
        unique case (r_state)
          ST_HUNT: begin
            w_state_nxt = ST_HUNT;
          end
          ST_DATA: begin
            if (w_is_one || w_is_bad) begin
              w_err       = 1'b1;
              w_state_nxt = ST_HUNT;
            end else begin
              if (!r_sym[0]) begin
                w_y_nxt = w_payload;
              end else begin
                w_pix_valid = 1'b1;
              end
              if (r_sym == LAST_SYM) begin
                w_sym_nxt = '0;
                if (r_line == LAST_LINE) begin
                  w_fdone     = 1'b1;
                  w_state_nxt = ST_HUNT;
                end else begin
                  w_bit_nxt   = '0;
                  w_state_nxt = ST_HSYNC;
                end
              end else begin
                w_sym_nxt = r_sym + SYM_W'(1);
              end
            end
          end
          ST_HSYNC: begin
            if (w_hs_exp ? !w_is_one : !w_is_zero) begin
              w_err       = 1'b1;
              w_state_nxt = ST_HUNT;
            end else if (r_bit == LAST_BIT) begin
              w_line_nxt  = r_line + LINE_W'(1);
              w_sym_nxt   = '0;
              w_state_nxt = ST_DATA;
            end else begin
              w_bit_nxt = r_bit + BIT_W'(1);
            end
          end
          default: begin
            w_state_nxt = ST_HUNT;
          end
        endcase
      end
    end
  end

  // Symbol, line and line-marker bit counters plus the held Y half of the pair.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_sym  <= '0;
      r_line <= '0;
      r_bit  <= '0;
      r_y    <= '0;
    end else begin
      r_sym  <= w_sym_nxt;
      r_line <= w_line_nxt;
      r_bit  <= w_bit_nxt;
      r_y    <= w_y_nxt;
    end
  end

  // Registered pixel pair, event pulses, error counter and lock flag.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      PixValid   <= 1'b0;
      PixY       <= '0;
      PixC       <= '0;
      PixLine    <= '0;
      PixCol     <= '0;
      FrameStart <= 1'b0;
      FrameOdd   <= 1'b0;
      FrameDone  <= 1'b0;
      SyncErr    <= 1'b0;
      ErrCount   <= '0;
      Locked     <= 1'b0;
    end else begin
      PixValid   <= w_pix_valid;
      FrameStart <= w_fstart;
      FrameDone  <= w_fdone;
      SyncErr    <= w_err;
      Locked     <= (w_state_nxt != ST_HUNT);
      if (w_pix_valid) begin
        PixY    <= r_y;
        PixC    <= w_payload;
        PixLine <= r_line;
        PixCol  <= SYM_W'(r_sym >> 1);
      end
      if (w_fstart) begin
        FrameOdd <= w_match1;
      end
      if (w_err && (ErrCount != {ERR_W{1'b1}})) begin
        ErrCount <= ErrCount + ERR_W'(1);
      end
    end
  end

endmodule
